adma_atx_sched: RTL and testbench



---
 rtl/adma_atx_sched_if.sv | 36 +++
 rtl/adma_atx_sched.sv | 144 ++++++++++++++
 tb/tb_adma_atx_sched.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adma_atx_sched_if.sv
// ============================================================================
// Module      : adma_atx_sched_if
// Description : Descriptor-in / ATX-request-out handshake bundle for the
//               ADMA ATX scheduler. The master side issues descriptors and
//               accepts ATX requests. The slave side is the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adma_atx_sched_if #(
  parameter int ADDR_W       = 32,
  parameter int DMA_LENGTH_W = 16
);
  logic                    tx_vld;
  logic                    tx_rdy;
  logic [ADDR_W-1:0]       tx_addr;
  logic [DMA_LENGTH_W-1:0] tx_len;
  logic                    atx_vld;
  logic                    atx_rdy;
  logic [ADDR_W-1:0]       atx_addr;
  logic [7:0]              atx_len;
  logic                    atx_last;
  logic                    atx_done;

  modport master (
    output tx_vld, tx_addr, tx_len, atx_rdy, atx_done,
    input  tx_rdy, atx_vld, atx_addr, atx_len, atx_last
  );

  modport slave (
    input  tx_vld, tx_addr, tx_len, atx_rdy, atx_done,
    output tx_rdy, atx_vld, atx_addr, atx_len, atx_last
  );
endinterface

`default_nettype wire

// File: rtl/adma_atx_sched.sv
// ============================================================================
// Module      : adma_atx_sched
// Description : Splits DMA descriptors (start address + beat count) into AXI
//               transactions (ATXs) of at most ATX_MAX_LEN beats and limits
//               the number of outstanding ATXs to ATX_NUM_OSTD.
//               Optional macro ADMA_ATX_4KB_SPLIT_EN: when defined, no ATX
//               crosses a 4 KB address boundary.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adma_atx_sched #(
  parameter int DMA_LENGTH_W = 16,
  parameter int ADDR_W       = 32,
  parameter int BEAT_BYTES   = 4,
  parameter int ATX_MAX_LEN  = 16,
  parameter int ATX_NUM_OSTD = 4
) (
  input  wire logic                              clk,
  input  wire logic                              rst,
  adma_atx_sched_if.slave                        bus,
  output logic [$clog2(ATX_NUM_OSTD+1)-1:0]      ostd_cnt,
  output logic                                   busy
);

  localparam int REM_W  = DMA_LENGTH_W + 1;
  localparam int OSTD_W = $clog2(ATX_NUM_OSTD + 1);
  localparam logic [OSTD_W-1:0] OSTD_MAX = OSTD_W'(ATX_NUM_OSTD);
  localparam logic [OSTD_W-1:0] OSTD_ONE = OSTD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPLIT = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [REM_W-1:0]    remaining_q, remaining_d;
  logic [7:0]          atx_len_q, atx_len_d;
  logic                atx_last_q, atx_last_d;
  logic [OSTD_W-1:0]   ostd_q, ostd_d;

  logic                w_atx_vld;
  logic                w_atx_hs;
  logic                w_done_eff;
  logic [31:0]         w_burst_cur;
  logic [31:0]         w_rem32;
  logic [31:0]         w_split;
`ifdef ADMA_ATX_4KB_SPLIT_EN
  logic [31:0]         w_bound;
`endif

  // Next-state, datapath and outstanding-count computation
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    atx_len_d   = atx_len_q;
    atx_last_d  = atx_last_q;
    ostd_d      = ostd_q;

    // Request is only offered while below the outstanding limit
    w_atx_vld   = (state_q == S_ISSUE) && (ostd_q < OSTD_MAX);
    w_atx_hs    = w_atx_vld && bus.atx_rdy;
    // A completion with nothing outstanding (and no same-cycle issue) is dropped
    w_done_eff  = bus.atx_done && ((ostd_q != '0) || w_atx_hs);

    // Beats in the ATX currently presented
    w_burst_cur = 32'(atx_len_q) + 32'd1;

    // Size of the next ATX: min(remaining, ATX_MAX_LEN[, 4 KB limit])
    w_rem32     = 32'(remaining_q);
    w_split     = (w_rem32 < 32'(ATX_MAX_LEN)) ? w_rem32 : 32'(ATX_MAX_LEN);
`ifdef ADMA_ATX_4KB_SPLIT_EN
    w_bound     = (32'd4096 - 32'(cur_addr_q[11:0])) >> $clog2(BEAT_BYTES);
    if (w_bound < w_split) begin
      w_split = w_bound;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.tx_vld) begin
          cur_addr_d  = bus.tx_addr;
          // Extra bit keeps an all-ones length from overflowing
          remaining_d = {1'b0, bus.tx_len} + {{DMA_LENGTH_W{1'b0}}, 1'b1};
          state_d     = S_SPLIT;
        end
      end
      S_SPLIT: begin
        atx_len_d  = 8'(w_split - 32'd1);
        atx_last_d = (w_split == w_rem32);
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_atx_hs) begin
          cur_addr_d  = cur_addr_q + ADDR_W'(w_burst_cur * 32'(BEAT_BYTES));
          remaining_d = remaining_q - REM_W'(w_burst_cur);
          state_d     = atx_last_q ? S_IDLE : S_SPLIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_atx_hs && !w_done_eff) begin
      ostd_d = ostd_q + OSTD_ONE;
    end else if (!w_atx_hs && w_done_eff) begin
      ostd_d = ostd_q - OSTD_ONE;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      atx_len_q   <= '0;
      atx_last_q  <= 1'b0;
      ostd_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      atx_len_q   <= atx_len_d;
      atx_last_q  <= atx_last_d;
      ostd_q      <= ostd_d;
    end
  end

  assign bus.tx_rdy   = (state_q == S_IDLE);
  assign bus.atx_vld  = w_atx_vld;
  assign bus.atx_addr = cur_addr_q;
  assign bus.atx_len  = atx_len_q;
  assign bus.atx_last = atx_last_q;
  assign ostd_cnt     = ostd_q;
  assign busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_adma_atx_sched.sv
// ============================================================================
// Module      : tb_adma_atx_sched
// Description : Self-checking bench for adma_atx_sched (default parameters).
//               Honours ADMA_ATX_4KB_SPLIT_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adma_atx_sched;

  localparam int MAXLEN = 16;
  localparam int OSTD   = 4;
  localparam int BB     = 4;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
  } atx_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    int          n;
    logic [31:0] f_addr;
    logic [7:0]  f_len;
    logic [31:0] l_addr;
    logic [7:0]  l_len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ostd_cnt;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  atx_t exp_q[$];
  atx_t obs_q[$];
  int   m_ostd = 0;
  bit   m_gap  = 1'b0;

  adma_atx_sched_if #(.ADDR_W(32), .DMA_LENGTH_W(16)) bus ();

  adma_atx_sched dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ostd_cnt (ostd_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Record every ATX handshake seen on the bus
  always @(posedge clk) begin
    if (!rst && bus.atx_vld && bus.atx_rdy) begin
      obs_q.push_back('{bus.atx_addr, bus.atx_len, bus.atx_last});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: split a descriptor into its ATX list from the rules directly
  function automatic void gen_atx(input logic [31:0] addr, input logic [15:0] len);
    longint unsigned rem, a, b, bnd;
    atx_t e;
    rem = longint'(len) + 1;
    a   = longint'(addr);
    while (rem > 0) begin
      b = (rem < MAXLEN) ? rem : MAXLEN;
`ifdef ADMA_ATX_4KB_SPLIT_EN
      bnd = (4096 - (a % 4096)) / BB;
      if (bnd < b) b = bnd;
`else
      bnd = 0;
`endif
      e.addr = 32'(a);
      e.len  = 8'(b - 1);
      e.last = (b == rem);
      exp_q.push_back(e);
      a   = (a + b * BB) % 64'h1_0000_0000;
      rem = rem - b;
    end
  endfunction

  function automatic bit m_rdy();
    return exp_q.size() == 0;
  endfunction

  function automatic bit m_vld();
    return (exp_q.size() != 0) && !m_gap && (m_ostd < OSTD);
  endfunction

  task automatic check_outputs();
    chk("tx_rdy",   64'(bus.tx_rdy),  64'(m_rdy()));
    chk("busy",     64'(busy),        64'(!m_rdy()));
    chk("atx_vld",  64'(bus.atx_vld), 64'(m_vld()));
    chk("ostd_cnt", 64'(ostd_cnt),    64'(m_ostd));
    if (exp_q.size() != 0 && !m_gap) begin
      chk("atx_addr", 64'(bus.atx_addr), 64'(exp_q[0].addr));
      chk("atx_len",  64'(bus.atx_len),  64'(exp_q[0].len));
      chk("atx_last", 64'(bus.atx_last), 64'(exp_q[0].last));
    end
  endtask

  // One clock: drive at negedge, advance model across the edge, check at next negedge
  task automatic step(input bit tv, input logic [31:0] ad, input logic [15:0] ln,
                      input bit ar, input bit dn);
    bit acc, hs, de;
    bus.tx_vld   = tv;
    bus.tx_addr  = ad;
    bus.tx_len   = ln;
    bus.atx_rdy  = ar;
    bus.atx_done = dn;
    acc = tv && m_rdy();
    hs  = m_vld() && ar;
    de  = dn && ((m_ostd > 0) || hs);
    @(posedge clk);
    m_ostd = m_ostd + int'(hs) - int'(de);
    if (acc) begin
      gen_atx(ad, ln);
      m_gap = 1'b1;
    end else if (hs) begin
      void'(exp_q.pop_front());
      m_gap = (exp_q.size() != 0);
    end else begin
      m_gap = 1'b0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset asserted between edges; called at a negedge
  task automatic do_reset();
    #2;
    rst          = 1'b1;
    bus.tx_vld   = 1'b0;
    bus.atx_rdy  = 1'b0;
    bus.atx_done = 1'b0;
    #1;
    chk("rst tx_rdy",   64'(bus.tx_rdy),   64'd1);
    chk("rst atx_vld",  64'(bus.atx_vld),  64'd0);
    chk("rst atx_addr", 64'(bus.atx_addr), 64'd0);
    chk("rst atx_len",  64'(bus.atx_len),  64'd0);
    chk("rst atx_last", 64'(bus.atx_last), 64'd0);
    chk("rst ostd_cnt", 64'(ostd_cnt),     64'd0);
    chk("rst busy",     64'(busy),         64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_ostd = 0;
    m_gap  = 1'b0;
    check_outputs();
  endtask

  // Feed one descriptor and drain it with always-ready / always-done
  task automatic run_desc(input logic [31:0] ad, input logic [15:0] ln, input int bound);
    obs_q.delete();
    step(1'b1, ad, ln, 1'b1, 1'b1);
    for (int c = 0; c < bound && exp_q.size() != 0; c++) begin
      step(1'b0, 32'h0, 16'h0, 1'b1, 1'b1);
    end
    if (exp_q.size() != 0) chk("drain timeout", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t vt[6];

  initial begin
    bit ok;
    vt[0] = '{32'h0, 16'd39, 3, 32'h0, 8'd15, 32'h80, 8'd7};
`ifdef ADMA_ATX_4KB_SPLIT_EN
    vt[1] = '{32'hFF8, 16'd3, 2, 32'hFF8, 8'd1, 32'h1000, 8'd1};
    vt[3] = '{32'hFFFF_FFF0, 16'd31, 3, 32'hFFFF_FFF0, 8'd3, 32'h40, 8'd11};
`else
    vt[1] = '{32'hFF8, 16'd3, 1, 32'hFF8, 8'd3, 32'hFF8, 8'd3};
    vt[3] = '{32'hFFFF_FFF0, 16'd31, 2, 32'hFFFF_FFF0, 8'd15, 32'h30, 8'd15};
`endif
    vt[2] = '{32'h100, 16'd0, 1, 32'h100, 8'd0, 32'h100, 8'd0};
    vt[4] = '{32'h1000, 16'd15, 1, 32'h1000, 8'd15, 32'h1000, 8'd15};
    vt[5] = '{32'h20, 16'd16, 2, 32'h20, 8'd15, 32'h60, 8'd0};

    bus.tx_vld = 1'b0; bus.tx_addr = '0; bus.tx_len = '0;
    bus.atx_rdy = 1'b0; bus.atx_done = 1'b0;
    @(negedge clk);
    do_reset();

    // Table-driven descriptors
    for (int i = 0; i < 6; i++) begin
      run_desc(vt[i].addr, vt[i].len, 200);
      chk($sformatf("vec%0d count", i), 64'(obs_q.size()), 64'(vt[i].n));
      if (obs_q.size() > 0) begin
        chk($sformatf("vec%0d first addr", i), 64'(obs_q[0].addr), 64'(vt[i].f_addr));
        chk($sformatf("vec%0d first len", i),  64'(obs_q[0].len),  64'(vt[i].f_len));
        chk($sformatf("vec%0d first last", i), 64'(obs_q[0].last), 64'(vt[i].n == 1));
        chk($sformatf("vec%0d last addr", i),  64'(obs_q[$].addr), 64'(vt[i].l_addr));
        chk($sformatf("vec%0d last len", i),   64'(obs_q[$].len),  64'(vt[i].l_len));
        chk($sformatf("vec%0d last flag", i),  64'(obs_q[$].last), 64'd1);
      end
      step(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    end

    // Outstanding limit: 4 ATXs then stall; one completion releases the 5th
    do_reset();
    obs_q.delete();
    step(1'b1, 32'h0, 16'd199, 1'b1, 1'b0);
    repeat (15) step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    chk("limit ostd", 64'(ostd_cnt), 64'd4);
    chk("limit vld",  64'(bus.atx_vld), 64'd0);
    chk("limit count", 64'(obs_q.size()), 64'd4);
    step(1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
    chk("release ostd", 64'(ostd_cnt), 64'd3);
    chk("release vld",  64'(bus.atx_vld), 64'd1);
    step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    chk("fifth count", 64'(obs_q.size()), 64'd5);
    chk("fifth ostd",  64'(ostd_cnt), 64'd4);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) step(1'b0, 32'h0, 16'h0, 1'b1, 1'b1);

    // Done at zero is ignored
    do_reset();
    step(1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
    chk("underflow ostd", 64'(ostd_cnt), 64'd0);

    // Stall stability and simultaneous issue/complete at ostd=2
    obs_q.delete();
    step(1'b1, 32'h0, 16'd63, 1'b0, 1'b0);
    for (int c = 0; c < 20 && obs_q.size() < 2; c++) step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    chk("pre ostd", 64'(ostd_cnt), 64'd2);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
      chk("stall vld",  64'(bus.atx_vld),  64'd1);
      chk("stall addr", 64'(bus.atx_addr), 64'h80);
      chk("stall len",  64'(bus.atx_len),  64'd15);
      chk("stall last", 64'(bus.atx_last), 64'd0);
    end
    step(1'b0, 32'h0, 16'h0, 1'b1, 1'b1);
    chk("same-cycle ostd", 64'(ostd_cnt), 64'd2);

    // Reset in the middle of a descriptor
    step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    do_reset();
    step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    chk("mid-rst tx_rdy", 64'(bus.tx_rdy), 64'd1);
    chk("mid-rst ostd",   64'(ostd_cnt),   64'd0);
    chk("mid-rst busy",   64'(busy),       64'd0);

    // All-ones length gives 2^16 beats
    run_desc(32'h0, 16'hFFFF, 20000);
    chk("max count", 64'(obs_q.size()), 64'd4096);
    if (obs_q.size() > 0) begin
      chk("max last addr", 64'(obs_q[$].addr), 64'h3FFC0);
      chk("max last len",  64'(obs_q[$].len),  64'd15);
      chk("max last flag", 64'(obs_q[$].last), 64'd1);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ra;
      if (c == 1500) do_reset();
      ra = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                       : (32'h0000_0F80 + 32'(4 * $urandom_range(0, 31)));
      step($urandom_range(0, 3) == 0, ra, 16'($urandom_range(0, 70)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4);
    end
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      step(1'b0, 32'h0, 16'h0, 1'b1, 1'b1);
    end
    chk("random drain", 64'(ok), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
